// File: rtl/ccff_chain_loader.sv
// Configuration-chain loader: takes bitstream words over valid/ready, shifts them LSB-first
// onto ccff_head under a gated programming clock, and optionally verifies the returning ccff_tail.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 4096,
  parameter int WORD_W    = 32,
  parameter int SETUP_CYC = 2,
  parameter int HOLD_CYC  = 2,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              cfg_clk_en,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam int WORDS  = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
  localparam int WCNT_W = $clog2(WORDS + 1);
  localparam int LEFT_W = $clog2(WORD_W + 1);
  localparam int PH_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]        r_state;
  logic [PH_W-1:0]   r_phase;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [WCNT_W-1:0] r_word_cnt;
  logic [WORD_W-1:0] r_hold_data;
  logic              r_hold_full;
  logic [WORD_W-1:0] r_sh_data;
  logic [LEFT_W-1:0] r_sh_left;
  logic              r_head;
  logic              r_clk_en;
  logic              r_cfg_en;
  logic              r_done;
  logic              r_verify;
  logic [CNT_W-1:0]  r_mis_cnt;

  logic w_start, w_in_shift, w_can_shift, w_sh_drain, w_ready, w_accept;
  logic w_setup_end, w_shift_end, w_hold_end, w_mismatch;

  assign w_start     = (r_state == ST_IDLE) && start;
  assign w_in_shift  = (r_state == ST_SHIFT);
  assign w_can_shift = w_in_shift && (r_sh_left != '0) && (r_bit_cnt < BIT_W'(CHAIN_LEN));
  // Shift register is empty now or after this cycle's shift: refill it so the next cycle can shift.
  assign w_sh_drain  = (r_sh_left == '0) || (w_can_shift && (r_sh_left == LEFT_W'(1)));
  assign w_ready     = w_in_shift && !r_hold_full && (r_word_cnt < WCNT_W'(WORDS));
  assign w_accept    = w_ready && s_valid;
  assign w_setup_end = (r_state == ST_SETUP) && (r_phase == PH_W'(SETUP_CYC - 1));
  assign w_shift_end = w_in_shift && (r_bit_cnt == BIT_W'(CHAIN_LEN));
  assign w_hold_end  = (r_state == ST_HOLD) && (r_phase == PH_W'(HOLD_CYC - 1));
  // The flop at the tail is overwritten on this edge; its old value is the previous load's bit.
  assign w_mismatch  = r_clk_en && r_verify && (ccff_tail != r_head);

  // Control FSM and phase counter shared by SETUP and HOLD.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_state  <= ST_IDLE;
      r_phase  <= '0;
      r_cfg_en <= 1'b0;
      r_done   <= 1'b0;
      r_verify <= 1'b0;
    end else begin
      // NOTE: every sequential assignment is non-blocking so all flops see pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state  <= ST_SETUP;
            r_phase  <= '0;
            r_cfg_en <= 1'b1;
            r_verify <= verify;
          end
        end
        ST_SETUP: begin
          if (w_setup_end) begin
            r_state <= ST_SHIFT;
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
        ST_SHIFT: begin
          if (w_shift_end) begin
            r_state <= ST_HOLD;
            r_phase <= '0;
          end
        end
        default: begin
          if (w_hold_end) begin
            r_state  <= ST_IDLE;
            r_cfg_en <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_phase <= r_phase + PH_W'(1);
          end
        end
      endcase
    end
  end

  // Word holding register, shift register and bit/word accounting.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_hold_data <= '0;
      r_hold_full <= 1'b0;
      r_sh_data   <= '0;
      r_sh_left   <= '0;
      r_head      <= 1'b0;
      r_clk_en    <= 1'b0;
    end else begin
      r_clk_en <= w_can_shift;
      if (w_start) begin
        r_bit_cnt   <= '0;
        r_word_cnt  <= '0;
        r_hold_full <= 1'b0;
        r_sh_left   <= '0;
      end else if (w_in_shift) begin
        if (w_can_shift) begin
          r_head    <= r_sh_data[0];
          r_sh_data <= r_sh_data >> 1;
          r_sh_left <= r_sh_left - LEFT_W'(1);
          r_bit_cnt <= r_bit_cnt + BIT_W'(1);
        end
        if (w_sh_drain) begin
          if (r_hold_full) begin
            r_sh_data   <= r_hold_data;
            r_sh_left   <= LEFT_W'(WORD_W);
            r_hold_full <= 1'b0;
          end else if (w_accept) begin
            r_sh_data <= s_data;
            r_sh_left <= LEFT_W'(WORD_W);
          end
        end
        if (w_accept) begin
          r_word_cnt <= r_word_cnt + WCNT_W'(1);
          if (!w_sh_drain) begin
            r_hold_data <= s_data;
            r_hold_full <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      r_mis_cnt <= '0;
    end else if (w_start) begin
      r_mis_cnt <= '0;
    end else if (w_mismatch && (r_mis_cnt != {CNT_W{1'b1}})) begin
      r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end
  end

  assign s_ready       = w_ready;
  assign ccff_head     = r_head;
  assign cfg_clk_en    = r_clk_en;
  assign config_enable = r_cfg_en;
  assign busy          = (r_state != ST_IDLE);
  assign done          = r_done;
  assign mismatch_cnt  = r_mis_cnt;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: an 8-flop and a 10-flop behavioural chain, expected head bits
// queued from the words driven and popped on every cfg_clk_en cycle.
module tb_ccff_chain_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel;
  logic       t_start, t_verify, t_valid;
  logic [3:0] t_data;

  logic a_ready, a_head, a_tail, a_clk_en, a_cfg_en, a_busy, a_done;
  logic b_ready, b_head, b_tail, b_clk_en, b_cfg_en, b_busy, b_done;
  logic [15:0] a_mis, b_mis;

  logic [7:0] chain8  = '0;
  logic [9:0] chain10 = '0;

  int n_tests = 0;
  int n_fail  = 0;
  logic q_exp[$];

  always #5 clk = ~clk;

  // Behavioural chains: head enters the top flop, tail is flop 0.
  always @(posedge clk) if (a_clk_en) chain8  <= {a_head, chain8[7:1]};
  always @(posedge clk) if (b_clk_en) chain10 <= {b_head, chain10[9:1]};
  assign a_tail = chain8[0];
  assign b_tail = chain10[0];

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(4), .SETUP_CYC(2), .HOLD_CYC(2), .CNT_W(16)) u_dut8 (
    .prog_clk(clk), .pReset_n(rst_n), .start(t_start & ~sel), .verify(t_verify),
    .s_data(t_data), .s_valid(t_valid & ~sel), .s_ready(a_ready), .ccff_head(a_head),
    .ccff_tail(a_tail), .cfg_clk_en(a_clk_en), .config_enable(a_cfg_en), .busy(a_busy),
    .done(a_done), .mismatch_cnt(a_mis));

  ccff_chain_loader #(.CHAIN_LEN(10), .WORD_W(4), .SETUP_CYC(2), .HOLD_CYC(2), .CNT_W(16)) u_dut10 (
    .prog_clk(clk), .pReset_n(rst_n), .start(t_start & sel), .verify(t_verify),
    .s_data(t_data), .s_valid(t_valid & sel), .s_ready(b_ready), .ccff_head(b_head),
    .ccff_tail(b_tail), .cfg_clk_en(b_clk_en), .config_enable(b_cfg_en), .busy(b_busy),
    .done(b_done), .mismatch_cnt(b_mis));

  logic m_ready, m_head, m_clk_en, m_cfg_en, m_busy, m_done;
  logic [9:0] m_chain;
  assign m_ready  = sel ? b_ready  : a_ready;
  assign m_head   = sel ? b_head   : a_head;
  assign m_clk_en = sel ? b_clk_en : a_clk_en;
  assign m_cfg_en = sel ? b_cfg_en : a_cfg_en;
  assign m_busy   = sel ? b_busy   : a_busy;
  assign m_done   = sel ? b_done   : a_done;
  assign m_chain  = sel ? chain10  : {2'b00, chain8};

  // One full load; words come LSB-first from wseq. After the last word s_valid stays high so
  // any extra acceptance shows up in 'taken'. 'starve' drops s_valid that many cycles after word 0.
  task automatic run_load(input bit sel_i, input int clen, input int nwords, input logic [11:0] wseq,
                          input bit vfy, input int starve, input bit poke_hold,
                          output int n_shift, output int n_done, output int gap, output int taken);
    int   wi = 0;
    int   scnt = 0;
    int   post = -1;
    int   cyc = 0;
    int   low_run = 0;
    bit   pend = 0;
    bit   shifted_any = 0;
    bit   poked = 0;
    logic exp_bit;
    logic last_head = 1'b0;
    n_shift = 0; n_done = 0; gap = 0; taken = 0;
    sel = sel_i;
    q_exp.delete();
    for (int b = 0; b < clen; b++) q_exp.push_back(wseq[b]);
    t_start = 1'b1; t_verify = vfy; t_valid = 1'b0;
    @(negedge clk);
    t_start = 1'b0; t_verify = 1'b0;
    while (post != 0 && cyc < 300) begin
      if (pend) begin wi++; taken++; end
      if (m_clk_en) begin
        n_shift++;
        if (shifted_any) gap += low_run;
        low_run = 0;
        shifted_any = 1;
        n_tests++;
        if (q_exp.size() == 0) begin
          n_fail++;
          $display("FAIL head_extra: shift %0d with no expected bit left", n_shift);
        end else begin
          exp_bit = q_exp.pop_front();
          if (m_head !== exp_bit) begin
            n_fail++;
            $display("FAIL head_bit[%0d]: got %b expected %b", n_shift - 1, m_head, exp_bit);
          end
        end
        last_head = m_head;
      end else if (shifted_any && m_busy && n_shift < clen) begin
        low_run++;
        n_tests++;
        if (m_head !== last_head) begin
          n_fail++;
          $display("FAIL head_stall: got %b expected %b", m_head, last_head);
        end
      end
      if (m_done) n_done++;
      if (post > 0) post--;
      else if (post < 0 && m_done) post = 3;
      if (poke_hold && !poked && n_shift == clen && m_busy && m_cfg_en && !m_clk_en) begin
        t_start = 1'b1; poked = 1;
      end else begin
        t_start = 1'b0;
      end
      if (wi == 1 && scnt < starve) begin
        t_valid = 1'b0; scnt++;
      end else begin
        t_valid = 1'b1;
        t_data  = (wi < nwords) ? wseq[4*wi +: 4] : 4'h0;
      end
      pend = t_valid && m_ready;
      @(negedge clk);
      cyc++;
    end
    t_valid = 1'b0; t_start = 1'b0;
    n_tests++;
    if (post != 0) begin
      n_fail++;
      $display("FAIL load_timeout: done not seen within %0d cycles", cyc);
    end
  endtask

  task automatic check_load(input string tag, input int clen, input int nwords, input logic [9:0] exp_chain,
                            input int n_shift, input int n_done, input int taken);
    n_tests += 5;
    if (n_shift !== clen) begin n_fail++; $display("FAIL %s_shifts: got %0d expected %0d", tag, n_shift, clen); end
    if (n_done !== 1)     begin n_fail++; $display("FAIL %s_done: got %0d pulses expected 1", tag, n_done); end
    if (taken !== nwords) begin n_fail++; $display("FAIL %s_words: got %0d expected %0d", tag, taken, nwords); end
    if (m_chain !== exp_chain) begin n_fail++; $display("FAIL %s_chain: got %h expected %h", tag, m_chain, exp_chain); end
    if (q_exp.size() != 0) begin n_fail++; $display("FAIL %s_pending: %0d bits never shifted", tag, q_exp.size()); end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({a_ready, a_head, a_clk_en, a_cfg_en, a_busy, a_done, a_mis, b_busy, b_cfg_en, b_clk_en} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected all zero",
               {a_ready, a_head, a_clk_en, a_cfg_en, a_busy, a_done, a_mis, b_busy, b_cfg_en, b_clk_en});
    end
  endtask

  task automatic test_basic_load();
    int ns, nd, gp, tk;
    run_load(1'b0, 8, 2, 12'h05A, 1'b0, 0, 1'b0, ns, nd, gp, tk);
    check_load("basic", 8, 2, 10'h05A, ns, nd, tk);
  endtask

  task automatic test_verify();
    int ns, nd, gp, tk;
    int exp_mis;
    exp_mis = $countones(chain8 ^ 8'h5A);
    run_load(1'b0, 8, 2, 12'h05A, 1'b1, 0, 1'b0, ns, nd, gp, tk);
    n_tests++;
    if (a_mis !== 16'(exp_mis)) begin n_fail++; $display("FAIL verify_same: got %0d expected %0d", a_mis, exp_mis); end
    exp_mis = $countones(chain8 ^ 8'h5F);
    run_load(1'b0, 8, 2, 12'h05F, 1'b1, 0, 1'b0, ns, nd, gp, tk);
    check_load("verify_diff", 8, 2, 10'h05F, ns, nd, tk);
    n_tests++;
    if (a_mis !== 16'(exp_mis)) begin n_fail++; $display("FAIL verify_diff: got %0d expected %0d", a_mis, exp_mis); end
  endtask

  task automatic test_partial_word();
    int ns, nd, gp, tk;
    run_load(1'b1, 10, 3, 12'hFC3, 1'b0, 0, 1'b0, ns, nd, gp, tk);
    check_load("partial", 10, 3, 10'h3C3, ns, nd, tk);
    sel = 1'b0;
  endtask

  task automatic test_starve();
    int ns, nd, gp, tk;
    // Word 0's four bits cover four of the eight starved cycles; the rest appear as clock gaps.
    run_load(1'b0, 8, 2, 12'h05A, 1'b0, 8, 1'b0, ns, nd, gp, tk);
    check_load("starve", 8, 2, 10'h05A, ns, nd, tk);
    n_tests++;
    if (gp !== 8 - 4 + 1) begin n_fail++; $display("FAIL starve_gap: got %0d expected %0d", gp, 5); end
  endtask

  task automatic test_async_reset();
    int ns, nd, gp, tk;
    int cyc = 0;
    sel = 1'b0;
    t_start = 1'b1; t_valid = 1'b1; t_data = 4'h3;
    @(negedge clk);
    t_start = 1'b0;
    while (!a_clk_en && cyc < 50) begin @(negedge clk); cyc++; end
    n_tests++;
    if (!a_clk_en) begin n_fail++; $display("FAIL areset_shift: got no shift expected one within 50 cycles"); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({a_ready, a_head, a_clk_en, a_cfg_en, a_busy, a_done, a_mis} !== '0) begin
      n_fail++;
      $display("FAIL areset_outputs: got %b expected all zero", {a_ready, a_head, a_clk_en, a_cfg_en, a_busy, a_done, a_mis});
    end
    t_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (a_busy !== 1'b0) begin n_fail++; $display("FAIL areset_idle: busy got %b expected 0", a_busy); end
    run_load(1'b0, 8, 2, 12'h05A, 1'b0, 0, 1'b0, ns, nd, gp, tk);
    check_load("after_reset", 8, 2, 10'h05A, ns, nd, tk);
  endtask

  task automatic test_ignore();
    int ns, nd, gp, tk;
    sel = 1'b0; t_valid = 1'b1; t_data = 4'hC;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (a_ready !== 1'b0 || a_busy !== 1'b0) begin
        n_fail++; $display("FAIL idle_valid: ready/busy got %b%b expected 00", a_ready, a_busy);
      end
    end
    run_load(1'b0, 8, 2, 12'h0C3, 1'b0, 0, 1'b1, ns, nd, gp, tk);
    check_load("hold_start", 8, 2, 10'h0C3, ns, nd, tk);
    repeat (4) begin
      @(negedge clk);
      n_tests++;
      if (a_busy !== 1'b0 || a_done !== 1'b0) begin
        n_fail++; $display("FAIL hold_start_idle: busy/done got %b%b expected 00", a_busy, a_done);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0;
    t_start = 1'b0; t_verify = 1'b0; t_valid = 1'b0; t_data = 4'h0;
    #1;
    test_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_basic_load();
    test_verify();
    test_partial_word();
    test_starve();
    test_async_reset();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
